cannon_pe: RTL and testbench
============================

Name: cannon_pe

Overview:
- Single processing element of the Cannon matrix-multiply grid. The grid is sqrt_p x sqrt_p; each PE holds one BS x BS block of A, B and C.
- Sits directly downstream of the grid controller and consumes its read, sum and shift command pulses.
- On a sum command it performs the block multiply-accumulate C += A*B using one MAC per cycle.
- On a shift command it takes A from its right neighbour and B from its lower neighbour.

Parameters:
- BS, 2, block edge length (n / sqrt_p); BS >= 1.
- W, 32, element width in bits (two's complement).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- load  in  1  one-cycle pulse: capture a_in/b_in, clear C.
- a_in  in  W*BS*BS  initial A block.
- b_in  in  W*BS*BS  initial B block.
- sum_start  in  1  one-cycle pulse: start C += A*B.
- shift  in  1  one-cycle pulse: A <= a_from_right, B <= b_from_below.
- a_from_right  in  W*BS*BS  right neighbour's a_out.
- b_from_below  in  W*BS*BS  lower neighbour's b_out.
- a_out  out  W*BS*BS  current A register.
- b_out  out  W*BS*BS  current B register.
- c_out  out  W*BS*BS  current C accumulator.
- busy  out  1  high while the MAC sequence runs.
- sum_done  out  1  one-cycle pulse when the MAC sequence completes.
- cmd_err  out  1  sticky flag: a command arrived while busy.

Behaviour:
- Packing: element (r,c) of any block is at bits [W*(r*BS+c) +: W].
- Reset (async): A, B, C = 0; state IDLE; busy, sum_done and cmd_err = 0; counters = 0.
- States: IDLE, MAC.
- IDLE command priority when several commands are sampled together: load > shift > sum_start. Lower-priority commands sampled on the same edge are dropped; cmd_err is not set.
- load: at the sampling edge, A <= a_in, B <= b_in, C <= 0. State stays IDLE.
- shift: at the sampling edge, A <= a_from_right, B <= b_from_below. a_out/b_out are registered, so all PEs shifting on the same edge exchange their pre-shift values. State stays IDLE.
- sum_start sampled at edge t:
  - Edge t: state <= MAC, i = j = k = 0, busy <= 1.
  - Edges t+1 .. t+BS^3: one accumulate per edge, C[i][j] <= C[i][j] + A[i][k]*B[k][j].
  - Loop order: k innermost, then j, then i.
  - Edge t+BS^3 (last accumulate) also sets state <= IDLE, busy <= 0, sum_done <= 1.
  - Edge t+BS^3+1: sum_done <= 0.
- Arithmetic: keep the low W bits of the product, then add modulo 2^W; wrap silently, no saturation.
- A and B are never modified by MAC.
- c_out reflects C on every cycle, including partial sums during MAC.
- In MAC, any load, shift or sum_start is ignored and sets cmd_err <= 1. cmd_err clears only on reset.
- Reset asserted mid-MAC: immediate abort; the sum_done pulse is never produced; all registers are zero after reset.
- A sum_start sampled on the same edge that sum_done is set is treated as in MAC: ignored, cmd_err set.
- A sum_start sampled while sum_done = 1 (state IDLE) is accepted normally.

Decomposition:
- Package cannon_pkg:
  - W default constant.
  - State enum typedef {IDLE, MAC}.
  - Element-offset function idx(r,c,BS) = W*(r*BS+c).
- Sub-module pe_mac (combinational): acc, a, b -> acc + low W bits of a*b, W-bit result. Instantiated once.
- i/j/k counters and the FSM live in cannon_pe.

Test Plan (BS=2, W=32):
- Reset: hold reset 3 cycles -> a_out = b_out = c_out = 0; busy = sum_done = cmd_err = 0.
- Basic product:
  - Stimulus: load A=[[1,2],[3,4]], B=[[5,6],[7,8]], then sum_start.
  - Response: busy high exactly 8 cycles; sum_done a single pulse; C=[[19,22],[43,50]]; A and B unchanged.
- Shift then accumulate:
  - Stimulus: after the basic product, shift with a_from_right=[[1,0],[0,1]], b_from_below=[[2,0],[0,2]], then sum_start.
  - Response: a_out/b_out take the new values one edge after shift; final C=[[21,22],[43,52]].
- Wrap and sign:
  - Stimulus: load A=[[0x10000,0],[0,0xFFFFFFFF]], B=[[0x10000,0],[0,3]], then sum.
  - Response: C[0][0]=0x00000000, C[1][1]=0xFFFFFFFD, others 0.
- Commands while busy:
  - Stimulus: on MAC cycle 3, pulse shift and load together.
  - Response: ignored; final C identical to the basic-product result; cmd_err = 1 and stays 1 until reset.
- Reset mid-MAC:
  - Stimulus: assert reset during MAC cycle 4.
  - Response: busy drops immediately; A = B = C = 0; no sum_done pulse ever follows.
  - Then load + sum with the basic-product operands -> C=[[19,22],[43,50]].

Source files
------------

// File: rtl/cannon_pkg.sv
// Shared types and helpers for the Cannon matrix-multiply processing element.
package cannon_pkg;

  localparam int W_DEFAULT = 32;

  typedef enum logic {IDLE, MAC} state_t;

  // Bit offset of element (r,c) inside a flattened row-major block.
  function automatic int idx(input int r, input int c, input int bs, input int w = W_DEFAULT);
    return w * (r * bs + c);
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Single multiply-accumulate step: acc + (a*b mod 2^W), wrapping modulo 2^W.
module pe_mac #(
  parameter int W = 32
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  // W-bit context keeps only the low W bits of the product and of the sum.
  assign sum = acc + a * b;

endmodule

// File: rtl/cannon_pe.sv
// Cannon grid processing element: holds A/B/C blocks, shifts A/B from its
// neighbours and runs C += A*B one MAC per cycle (k innermost, then j, then i).
module cannon_pe
  import cannon_pkg::*;
#(
  parameter int BS = 2,
  parameter int W  = W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [W*BS*BS-1:0]   a_in,
  input  logic [W*BS*BS-1:0]   b_in,
  input  logic                 sum_start,
  input  logic                 shift,
  input  logic [W*BS*BS-1:0]   a_from_right,
  input  logic [W*BS*BS-1:0]   b_from_below,
  output logic [W*BS*BS-1:0]   a_out,
  output logic [W*BS*BS-1:0]   b_out,
  output logic [W*BS*BS-1:0]   c_out,
  output logic                 busy,
  output logic                 sum_done,
  output logic                 cmd_err
);

  localparam int N  = BS * BS;
  localparam int CW = (BS > 1) ? $clog2(BS) : 1;
  localparam int AW = (W * N > 1) ? $clog2(W * N) : 1;
  localparam logic [CW-1:0] CMAX = CW'(BS - 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  i, j, k;
  logic [W*N-1:0] a_q, b_q, c_q;
  logic [AW-1:0]  a_base, b_base, c_base;
  logic [W-1:0]   c_nxt;
  logic           last, any_cmd;

  assign any_cmd = load | shift | sum_start;
  assign last    = (i == CMAX) && (j == CMAX) && (k == CMAX);

  assign a_base = AW'(idx(int'(i), int'(k), BS, W));
  assign b_base = AW'(idx(int'(k), int'(j), BS, W));
  assign c_base = AW'(idx(int'(i), int'(j), BS, W));

  pe_mac #(.W(W)) u_mac (
    .acc (c_q[c_base +: W]),
    .a   (a_q[a_base +: W]),
    .b   (b_q[b_base +: W]),
    .sum (c_nxt)
  );

  assign a_out = a_q;
  assign b_out = b_q;
  assign c_out = c_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // load and shift outrank sum_start when sampled together.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sum_start && !load && !shift) state_nxt = MAC;
      MAC:  if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MAC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      sum_done <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      sum_done <= 1'b0;
      if (state == IDLE) begin
        if (load) begin
          a_q <= a_in;
          b_q <= b_in;
          c_q <= '0;
        end else if (shift) begin
          a_q <= a_from_right;
          b_q <= b_from_below;
        end else if (sum_start) begin
          i <= '0;
          j <= '0;
          k <= '0;
        end
      end else begin
        c_q[c_base +: W] <= c_nxt;
        if (any_cmd) cmd_err <= 1'b1;
        if (last) begin
          i        <= '0;
          j        <= '0;
          k        <= '0;
          sum_done <= 1'b1;
        end else if (k == CMAX) begin
          k <= '0;
          if (j == CMAX) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cannon_pe.sv
// Self-checking bench for cannon_pe (BS=2, W=32): block-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_cannon_pe;

  localparam int BS = 2;
  localparam int W  = 32;
  localparam int N  = BS * BS;
  localparam int BW = N * W;

  typedef logic [N-1:0][W-1:0] blk_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0, sum_start = 1'b0, shift = 1'b0;
  blk_t a_in = '0, b_in = '0, a_fr = '0, b_fb = '0;
  blk_t a_out, b_out, c_out;
  logic busy, sum_done, cmd_err;

  always #5 clk = ~clk;

  cannon_pe #(.BS(BS), .W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .a_in         (a_in),
    .b_in         (b_in),
    .sum_start    (sum_start),
    .shift        (shift),
    .a_from_right (a_fr),
    .b_from_below (b_fb),
    .a_out        (a_out),
    .b_out        (b_out),
    .c_out        (c_out),
    .busy         (busy),
    .sum_done     (sum_done),
    .cmd_err      (cmd_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int busy_cyc = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic blk_t mk(input logic [W-1:0] e00, e01, e10, e11);
    blk_t b;
    b[0] = e00; b[1] = e01; b[2] = e10; b[3] = e11;
    return b;
  endfunction

  // Reference model: a sum command precomputes every partial C in loop order;
  // each busy cycle retires one snapshot.
  blk_t mA, mB, mC, tmp;
  blk_t snap_q[$];
  bit   m_done, m_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mA = '0; mB = '0; mC = '0;
      snap_q.delete();
      m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      if (snap_q.size() > 0) begin
        if (load || shift || sum_start) m_err = 1;
        mC = snap_q.pop_front();
        m_done = (snap_q.size() == 0);
      end else if (load) begin
        mA = a_in; mB = b_in; mC = '0;
      end else if (shift) begin
        mA = a_fr; mB = b_fb;
      end else if (sum_start) begin
        tmp = mC;
        for (int r = 0; r < BS; r++)
          for (int c = 0; c < BS; c++)
            for (int x = 0; x < BS; x++) begin
              tmp[r*BS+c] = tmp[r*BS+c] + mA[r*BS+x] * mB[x*BS+c];
              snap_q.push_back(tmp);
            end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chk("a_out", a_out, mA);
    chk("b_out", b_out, mB);
    chk("c_out", c_out, mC);
    chk("busy", BW'(busy), BW'(snap_q.size() > 0));
    chk("sum_done", BW'(sum_done), BW'(m_done));
    chk("cmd_err", BW'(cmd_err), BW'(m_err));
    busy_cyc += int'(busy);
    done_cnt += int'(sum_done);
  end

  task automatic do_load(input blk_t a, input blk_t b);
    @(negedge clk); load = 1'b1; a_in = a; b_in = b;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic pulse_sum();
    @(negedge clk); sum_start = 1'b1;
    @(negedge clk); sum_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
    end
    @(negedge clk);
  endtask

  blk_t A1, B1, C1;

  initial begin
    A1 = mk(1, 2, 3, 4);
    B1 = mk(5, 6, 7, 8);
    C1 = mk(19, 22, 43, 50);

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a", a_out, '0);
    chk("rst_b", b_out, '0);
    chk("rst_c", c_out, '0);
    chk("rst_flags", BW'({busy, sum_done, cmd_err}), '0);
    reset = 1'b0;

    // basic product
    do_load(A1, B1);
    busy_cyc = 0; done_cnt = 0;
    pulse_sum();
    wait_idle();
    chk("basic_busy_cycles", BW'(busy_cyc), BW'(8));
    chk("basic_done_pulses", BW'(done_cnt), BW'(1));
    chk("basic_c", c_out, C1);
    chk("basic_a", a_out, A1);
    chk("basic_b", b_out, B1);

    // shift then accumulate
    @(negedge clk); shift = 1'b1; a_fr = mk(1, 0, 0, 1); b_fb = mk(2, 0, 0, 2);
    @(negedge clk); shift = 1'b0;
    chk("shift_a", a_out, mk(1, 0, 0, 1));
    chk("shift_b", b_out, mk(2, 0, 0, 2));
    pulse_sum();
    wait_idle();
    chk("shift_c", c_out, mk(21, 22, 43, 52));

    // wrap and sign
    do_load(mk(32'h10000, 0, 0, 32'hFFFFFFFF), mk(32'h10000, 0, 0, 3));
    pulse_sum();
    wait_idle();
    chk("wrap_c", c_out, mk(32'h0, 0, 0, 32'hFFFFFFFD));
    chk("wrap_no_err", BW'(cmd_err), '0);

    // commands while busy
    do_load(A1, B1);
    pulse_sum();
    @(negedge clk);
    shift = 1'b1; load = 1'b1; a_in = mk(9, 9, 9, 9); a_fr = mk(7, 7, 7, 7);
    @(negedge clk);
    shift = 1'b0; load = 1'b0;
    wait_idle();
    chk("busycmd_c", c_out, C1);
    chk("busycmd_a", a_out, A1);
    chk("busycmd_err", BW'(cmd_err), BW'(1));
    repeat (4) @(negedge clk);
    chk("busycmd_err_sticky", BW'(cmd_err), BW'(1));

    // reset mid-MAC
    do_load(A1, B1);
    pulse_sum();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", BW'(busy), '0);
    chk("midrst_a", a_out, '0);
    chk("midrst_b", b_out, '0);
    chk("midrst_c", c_out, '0);
    chk("midrst_err", BW'(cmd_err), '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", BW'(done_cnt), '0);
    do_load(A1, B1);
    pulse_sum();
    wait_idle();
    chk("midrst_recover_c", c_out, C1);

    // sum_start on the completing edge is rejected; one cycle later it is accepted
    do_load(A1, B1);
    pulse_sum();
    repeat (6) @(negedge clk);
    @(negedge clk); sum_start = 1'b1;
    @(negedge clk);
    chk("edge_done_pulse", BW'(sum_done), BW'(1));
    @(negedge clk); sum_start = 1'b0;
    chk("edge_rerun_busy", BW'(busy), BW'(1));
    wait_idle();
    chk("edge_c", c_out, mk(38, 44, 86, 100));
    chk("edge_err", BW'(cmd_err), BW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
